// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and default oversampling.
package uart_pkg;

  localparam int UART_DATA_BITS          = 8;
  localparam int UART_OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous, idle-high line; all stages reset to 1.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw line one stage deeper per clock.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchronizer flops; reset to the idle (high) level so no false start follows reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-of-3 mid-bit voting and a valid/ready byte output.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for a low level on rx_s
// START     | inside the start bit, confirming it at mid-bit
// DATA      | sampling the 8 data bits, LSB first
// STOP      | checking the stop bit; deliver byte, overrun or framing error
// WAIT_IDLE | after a framing error, wait for the line to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = UART_OVERSAMPLE_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      RX,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  input  logic                      ready,
  output logic                      busy,
  output logic                      framing_err,
  output logic                      overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_PRE  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] TICK_SMP  = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

  logic rx_s;

  uart_state_e               state_q, state_d;
  logic [TW-1:0]             tick_q, tick_d, tick_next;
  logic [1:0]                vote_q, vote_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      framing_err_q, framing_err_d;
  logic                      overrun_q, overrun_d;
  logic                      sample;
  logic                      mid_hit;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (RX),
    .q     (rx_s)
  );

  assign tick_next = (tick_q == TICK_LAST) ? '0 : tick_q + TW'(1);
  assign sample    = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
  assign mid_hit   = (tick_q == TICK_SMP);

  // Next-state, bit timing, shifting and output handshake.
  always_comb begin
    state_d       = state_q;
    tick_d        = tick_q;
    vote_d        = vote_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    data_d        = data_q;
    valid_d       = valid_q;
    framing_err_d = 1'b0;
    overrun_d     = 1'b0;

    if (valid_q && ready) valid_d = 1'b0;
    if (tick_q == TICK_PRE) vote_d[0] = rx_s;
    if (tick_q == TICK_MID) vote_d[1] = rx_s;

    unique case (state_q)
      IDLE: begin
        tick_d = '0;
        // The cycle the falling edge is seen is count 0, so the counter is
        // cleared here and enters START already at 1; the vote then centres
        // on the true middle of each bit.
        if (!rx_s) begin
          state_d = START;
          tick_d  = TW'(1);
        end
      end
      START: begin
        tick_d = tick_next;
        if (mid_hit) begin
          if (!sample) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        tick_d = tick_next;
        if (mid_hit) begin
          shift_d = {sample, shift_q[UART_DATA_BITS-1:1]};
          if (bit_idx_q == BIT_LAST) state_d = STOP;
          else                       bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        tick_d = tick_next;
        if (mid_hit) begin
          if (sample) begin
            // A byte being consumed this cycle frees the slot for the new one.
            if (!valid_q || ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
            state_d = IDLE;
          end else begin
            framing_err_d = 1'b1;
            state_d       = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        tick_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      tick_q        <= '0;
      vote_q        <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      vote_q        <= vote_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      framing_err_q <= framing_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign busy        = (state_q != IDLE);
  assign framing_err = framing_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: good frames, false start, framing error, overrun,
// back-to-back frames with baud skew, and reset in mid-frame.
module tb_uart_rx;

  localparam int CLK_NS = 10;
  localparam int BIT_NS = 160;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       framing_err;
  logic       overrun;

  int n_tests = 0;
  int n_fail  = 0;

  int         acc_cnt = 0;
  int         fe_cnt  = 0;
  int         ov_cnt  = 0;
  int         vhi_cnt = 0;
  logic [7:0] acc_log [0:63];

  always #(CLK_NS / 2) clk = ~clk;

  uart_rx #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (rx),
    .data        (data),
    .valid       (valid),
    .ready       (ready),
    .busy        (busy),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  // Observe handshakes and pulses away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && ready) begin
        acc_log[acc_cnt % 64] = data;
        acc_cnt++;
      end
      if (framing_err) fe_cnt++;
      if (overrun)     ov_cnt++;
      if (valid)       vhi_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one 8N1 frame; leaves the line at the stop-bit level.
  task automatic send_byte(input logic [7:0] b, input logic stop_v, input int bit_ns);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_v;
    #(bit_ns);
  endtask

  initial begin
    int b_acc, b_fe, b_ov, b_vhi;
    int periods [3];
    logic [7:0] frame;
    periods[0] = 160;
    periods[1] = 155;
    periods[2] = 165;

    #33;
    check("rst_data",  32'(data), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_ferr",  32'(framing_err), 32'h0);
    check("rst_ovr",   32'(overrun), 32'h0);
    rst_n = 1'b1;
    #53;

    // Single good frame, consumer always ready.
    ready = 1'b1;
    b_acc = acc_cnt; b_fe = fe_cnt; b_vhi = vhi_cnt;
    send_byte(8'hA5, 1'b1, BIT_NS);
    check("a5_busy_after_stop", 32'(busy), 32'h0);
    #200;
    check("a5_count", 32'(acc_cnt - b_acc), 32'd1);
    check("a5_data", 32'(acc_log[b_acc % 64]), 32'hA5);
    check("a5_valid_cycles", 32'(vhi_cnt - b_vhi), 32'd1);
    check("a5_ferr", 32'(fe_cnt - b_fe), 32'd0);

    // 4-cycle glitch must abort in START.
    b_acc = acc_cnt; b_fe = fe_cnt;
    rx = 1'b0;
    #(4 * CLK_NS);
    rx = 1'b1;
    #400;
    check("glitch_busy", 32'(busy), 32'h0);
    check("glitch_valid", 32'(valid), 32'h0);
    check("glitch_ferr", 32'(fe_cnt - b_fe), 32'd0);
    check("glitch_count", 32'(acc_cnt - b_acc), 32'd0);
    send_byte(8'h3C, 1'b1, BIT_NS);
    #200;
    check("3c_count", 32'(acc_cnt - b_acc), 32'd1);
    check("3c_data", 32'(acc_log[b_acc % 64]), 32'h3C);

    // Framing error followed by a held break.
    b_acc = acc_cnt; b_fe = fe_cnt;
    send_byte(8'h81, 1'b0, BIT_NS);
    #400;
    check("brk_ferr", 32'(fe_cnt - b_fe), 32'd1);
    check("brk_busy_wait", 32'(busy), 32'h1);
    check("brk_valid", 32'(valid), 32'h0);
    check("brk_count", 32'(acc_cnt - b_acc), 32'd0);
    rx = 1'b1;
    #200;
    check("brk_busy_after", 32'(busy), 32'h0);
    check("brk_ferr_single", 32'(fe_cnt - b_fe), 32'd1);
    send_byte(8'h55, 1'b1, BIT_NS);
    #200;
    check("55_count", 32'(acc_cnt - b_acc), 32'd1);
    check("55_data", 32'(acc_log[b_acc % 64]), 32'h55);

    // Overrun: two frames with the consumer stalled.
    ready = 1'b0;
    b_acc = acc_cnt; b_ov = ov_cnt;
    send_byte(8'h12, 1'b1, BIT_NS);
    send_byte(8'h34, 1'b1, BIT_NS);
    #200;
    check("ovr_valid", 32'(valid), 32'h1);
    check("ovr_data", 32'(data), 32'h12);
    check("ovr_pulse", 32'(ov_cnt - b_ov), 32'd1);
    ready = 1'b1;
    #1;
    check("ovr_data_at_ready", 32'(data), 32'h12);
    #40;
    check("ovr_accepted", 32'(acc_cnt - b_acc), 32'd1);
    check("ovr_accepted_data", 32'(acc_log[b_acc % 64]), 32'h12);
    check("ovr_valid_cleared", 32'(valid), 32'h0);

    // Back-to-back frames at nominal, fast and slow baud.
    for (int p = 0; p < 3; p++) begin
      b_acc = acc_cnt; b_ov = ov_cnt; b_fe = fe_cnt;
      send_byte(8'h00, 1'b1, periods[p]);
      send_byte(8'hFF, 1'b1, periods[p]);
      send_byte(8'h01, 1'b1, periods[p]);
      #300;
      check($sformatf("b2b%0d_count", periods[p]), 32'(acc_cnt - b_acc), 32'd3);
      check($sformatf("b2b%0d_d0", periods[p]), 32'(acc_log[b_acc % 64]), 32'h00);
      check($sformatf("b2b%0d_d1", periods[p]), 32'(acc_log[(b_acc + 1) % 64]), 32'hFF);
      check($sformatf("b2b%0d_d2", periods[p]), 32'(acc_log[(b_acc + 2) % 64]), 32'h01);
      check($sformatf("b2b%0d_errs", periods[p]), 32'((fe_cnt - b_fe) + (ov_cnt - b_ov)), 32'd0);
    end

    // Reset during data bit 4 with a byte already pending.
    ready = 1'b0;
    send_byte(8'h5A, 1'b1, BIT_NS);
    #200;
    check("pre_rst_valid", 32'(valid), 32'h1);
    check("pre_rst_data", 32'(data), 32'h5A);
    frame = 8'hC3;
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx = frame[i];
      #(BIT_NS);
    end
    rx = frame[4];
    #(BIT_NS / 2);
    check("mid_busy_before_rst", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst_data", 32'(data), 32'h0);
    check("arst_valid", 32'(valid), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    rx = 1'b1;
    #47;
    rst_n = 1'b1;
    ready = 1'b1;
    #200;
    b_acc = acc_cnt;
    send_byte(8'hC3, 1'b1, BIT_NS);
    #200;
    check("c3_count", 32'(acc_cnt - b_acc), 32'd1);
    check("c3_data", 32'(acc_log[b_acc % 64]), 32'hC3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
